branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Multi-cycle control sequencer for conditional branch instructions (`br` class).
- Accepts a latched branch instruction and the incremented PC from the main control unit.
- Requests register Ra onto the shared bus and evaluates the 2-bit condition against the bus value.
- Latches the result into the CON flip-flop and, when taken, loads the branch target into PC.
- Sits between the control unit (start/done handshake), the register file read port and the PC register.

## Interface
Parameters:
- `DATA_W`, 32, bus, PC and register width
- `OFF_W`, 19, displacement width (IR[18:0])

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  branch request from control unit; accepted only when `ready`=1
- `ready`  out  1  sequencer idle, can accept `start`
- `ir`  in  32  instruction word, sampled on accept
- `pc_in`  in  DATA_W  already-incremented PC, sampled on accept
- `reg_sel`  out  4  register index to drive onto bus (Ra = IR[26:23])
- `reg_rd`  out  1  register-file bus-drive request
- `bus_data`  in  DATA_W  shared bus value
- `con_ff`  out  1  latched branch condition
- `pc_out`  out  DATA_W  next PC value
- `pc_load`  out  1  one-cycle PC write strobe
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, EVAL, UPDATE.
- **IDLE**
  - `ready`=1.
  - On `start`=1: capture `ir` and `pc_in`, go to READ.
- **READ**
  - `reg_rd`=1, `reg_sel`=IR[26:23].
  - Go to EVAL.
- **EVAL**
  - `reg_rd`=1, `reg_sel` held.
  - At the end of the cycle, latch `con_ff` from `bus_data` using C2=IR[20:19]:
    - 00: taken if bus == 0
    - 01: taken if bus != 0
    - 10: taken if signed bus > 0
    - 11: taken if signed bus < 0
  - Go to UPDATE.
- **UPDATE**
  - `done`=1.
  - `pc_out` = captured PC + sign-extended IR[18:0], computed modulo 2^DATA_W (wrap, no overflow flag).
  - `pc_load` = `con_ff`.
  - Go to IDLE.
- Not-taken branch: `pc_load`=0, `done` still pulses. PC is unchanged.
- `pc_out` holds its last value outside UPDATE. `pc_load` is the only write qualifier.
- `con_ff` holds until the next EVAL.
- `start` outside IDLE is ignored. No queuing.
- Unknown opcode field is not checked; the control unit only asserts `start` for branches.

## Timing
- Reset values: `ready`=1, `reg_rd`=0, `reg_sel`=0, `con_ff`=0, `pc_out`=0, `pc_load`=0, `done`=0, state IDLE.
- `rst_n` low mid-operation forces IDLE immediately (async) and clears all outputs.
  - No `pc_load` or `done` is issued for an aborted branch.
- Latency: with the accept edge at cycle k, READ is cycle k+1, EVAL is k+2, UPDATE (`done`/`pc_load`) is k+3.
- Fixed 3-cycle occupancy. `ready` returns high at k+4.
- Back-to-back: `start` held high across `done` is accepted at the k+4 edge, giving the next `done` at k+7.
- `bus_data` is sampled only on the EVAL→UPDATE edge. Bus values during READ are don't-care.
- Outputs are registered (Moore). No combinational path from `bus_data` or `start` to any output.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds outputs `taken_cnt` [15:0] and `not_taken_cnt` [15:0].
  - In UPDATE, exactly one counter increments per completed branch.
  - Counters saturate at 16'hFFFF.
  - Both reset to 0 on `rst_n`.
- `BRANCH_STATS_EN` undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg` holds:
  - condition encodings `COND_ZERO`/`COND_NZ`/`COND_POS`/`COND_NEG`
  - IR field positions (Ra, C2, displacement)
  - state enum `br_state_t`
- One sub-module: `branch_cond_eval`, combinational (C2, bus value) → taken bit.
  - Instantiated once and registered into `con_ff` in the parent.
- Sign extension and target adder live in the parent.

## Test plan
- Reset, then `start` with C2=00, Ra=3, `bus_data`=0, `pc_in`=0x100, disp=+0x10:
  - `done` at k+3, `con_ff`=1, `pc_load`=1, `pc_out`=0x110.
- C2=01, `bus_data`=0:
  - `con_ff`=0, `pc_load`=0, `done`=1.
  - PC target still computed, 0x110.
- C2=10 with `bus_data`=0x8000_0000, then C2=11 with the same value:
  - first not taken, second taken.
  - disp=0x7FFFF (−1) gives `pc_out`=pc_in−1.
- `pc_in`=0xFFFF_FFF0, disp=+0x20:
  - `pc_out`=0x0000_0010 (wrap).
- `start` held high continuously:
  - accepts every 4 cycles.
  - `start` pulses during READ/EVAL/UPDATE are ignored.
- `rst_n` asserted in EVAL:
  - all outputs 0 at once, `ready`=1.
  - no `done` after release.
  - With `BRANCH_STATS_EN`, counters are 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared IR field positions, branch condition codes and sequencer states
package cpu_pkg;

   localparam int IR_W     = 32;
   localparam int RA_MSB   = 26;
   localparam int RA_LSB   = 23;
   localparam int C2_MSB   = 20;
   localparam int C2_LSB   = 19;
   localparam int DISP_LSB = 0;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      COND_ZERO = 2'b00,
      COND_NZ   = 2'b01,
      COND_POS  = 2'b10,
      COND_NEG  = 2'b11
   } cond_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      EVAL   = 2'd2,
      UPDATE = 2'd3
   } br_state_t;

   // Statistics counters stick at all-ones rather than wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// rtl/branch_sequencer_if.sv - control-unit / register-file / PC handshake bundle of the branch sequencer
// BRANCH_STATS_EN adds the taken / not-taken counters to the bundle.
interface branch_sequencer_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
);

   logic              start;
   logic              ready;
   logic [IR_W-1:0]   ir;
   logic [DATA_W-1:0] pc_in;
   logic [3:0]        reg_sel;
   logic              reg_rd;
   logic [DATA_W-1:0] bus_data;
   logic              con_ff;
   logic [DATA_W-1:0] pc_out;
   logic              pc_load;
   logic              done;
`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0]  taken_cnt;
   logic [CNT_W-1:0]  not_taken_cnt;
`endif

`ifdef BRANCH_STATS_EN
   modport master (
      output start, ir, pc_in, bus_data,
      input  ready, reg_sel, reg_rd, con_ff, pc_out, pc_load, done,
      input  taken_cnt, not_taken_cnt
   );

   modport slave (
      input  start, ir, pc_in, bus_data,
      output ready, reg_sel, reg_rd, con_ff, pc_out, pc_load, done,
      output taken_cnt, not_taken_cnt
   );
`else
   modport master (
      output start, ir, pc_in, bus_data,
      input  ready, reg_sel, reg_rd, con_ff, pc_out, pc_load, done
   );

   modport slave (
      input  start, ir, pc_in, bus_data,
      output ready, reg_sel, reg_rd, con_ff, pc_out, pc_load, done
   );
`endif

endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition test of a bus value against C2
module branch_cond_eval
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  cond_t             c2,
   input  logic [DATA_W-1:0] value,
   output logic              taken
);

   logic is_zero;
   logic is_neg;

   assign is_zero = (value == '0);
   assign is_neg  = value[DATA_W-1];

   always_comb begin
      taken = 1'b0;
      case (c2)
         COND_ZERO: taken = is_zero;
         COND_NZ:   taken = !is_zero;
         COND_POS:  taken = !is_neg && !is_zero;
         COND_NEG:  taken = is_neg;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - four-state conditional branch sequencer (read Ra, test C2, load PC)
// BRANCH_STATS_EN adds saturating taken / not-taken branch counters.
module branch_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = 19
) (
   input logic                clk,
   input logic                rst_n,
   branch_sequencer_if.slave  bif
);

   br_state_t state;
   br_state_t state_d;

   logic [3:0]        ra_q;
   cond_t             c2_q;
   logic [OFF_W-1:0]  disp_q;
   logic [DATA_W-1:0] pc_q;

   logic              ready_q,   ready_d;
   logic              reg_rd_q,  reg_rd_d;
   logic              done_q,    done_d;
   logic              pc_load_q, pc_load_d;
   logic              con_q,     con_d;
   logic [DATA_W-1:0] pc_out_q,  pc_out_d;

   logic              accept;
   logic              taken;
   logic [DATA_W-1:0] disp_sext;
   logic [DATA_W-1:0] target;

   // Opcode and Rb fields are decoded by the control unit, not here.
   logic unused_ir;
   assign unused_ir = ^{bif.ir[IR_W-1:RA_MSB+1], bif.ir[RA_LSB-1:C2_MSB+1]};

   assign accept    = (state == IDLE) && bif.start;
   assign disp_sext = {{(DATA_W-OFF_W){disp_q[OFF_W-1]}}, disp_q};
   assign target    = pc_q + disp_sext;

   branch_cond_eval #(
      .DATA_W (DATA_W)
   ) u_cond (
      .c2    (c2_q),
      .value (bif.bus_data),
      .taken (taken)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Every output is decoded from the next state so it leaves a flop.
   always_comb begin
      state_d   = state;
      con_d     = con_q;
      pc_out_d  = pc_out_q;
      pc_load_d = 1'b0;
      case (state)
         IDLE:   if (bif.start) state_d = READ;
         READ:   state_d = EVAL;
         EVAL: begin
            state_d   = UPDATE;
            con_d     = taken;
            pc_out_d  = target;
            pc_load_d = taken;
         end
         UPDATE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d  = (state_d == IDLE);
      reg_rd_d = (state_d == READ) || (state_d == EVAL);
      done_d   = (state_d == UPDATE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b1;
         reg_rd_q  <= 1'b0;
         done_q    <= 1'b0;
         pc_load_q <= 1'b0;
         con_q     <= 1'b0;
         pc_out_q  <= '0;
      end else begin
         ready_q   <= ready_d;
         reg_rd_q  <= reg_rd_d;
         done_q    <= done_d;
         pc_load_q <= pc_load_d;
         con_q     <= con_d;
         pc_out_q  <= pc_out_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra_q   <= '0;
         c2_q   <= COND_ZERO;
         disp_q <= '0;
         pc_q   <= '0;
      end else if (accept) begin
         ra_q   <= bif.ir[RA_MSB:RA_LSB];
         c2_q   <= cond_t'(bif.ir[C2_MSB:C2_LSB]);
         disp_q <= bif.ir[DISP_LSB +: OFF_W];
         pc_q   <= bif.pc_in;
      end
   end

   assign bif.ready   = ready_q;
   assign bif.reg_sel = ra_q;
   assign bif.reg_rd  = reg_rd_q;
   assign bif.con_ff  = con_q;
   assign bif.pc_out  = pc_out_q;
   assign bif.pc_load = pc_load_q;
   assign bif.done    = done_q;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] taken_cnt_q;
   logic [CNT_W-1:0] not_taken_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_q     <= '0;
         not_taken_cnt_q <= '0;
      end else if (state == EVAL) begin
         if (taken) begin
            taken_cnt_q <= sat_inc(taken_cnt_q);
         end else begin
            not_taken_cnt_q <= sat_inc(not_taken_cnt_q);
         end
      end
   end

   assign bif.taken_cnt     = taken_cnt_q;
   assign bif.not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer with directed branch vectors
module tb_branch_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   pcyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_total = 0;
   int   exp_taken = 0;
   int   exp_nt = 0;

   typedef struct {
      int          done_cyc;
      logic [3:0]  ra;
      logic        con;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   branch_sequencer_if #(.DATA_W(32)) bif();

   branch_sequencer #(
      .DATA_W (32),
      .OFF_W  (19)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) pcyc <= pcyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, pcyc);
      end
   endfunction

   // Monitor: checks the in-flight branch every cycle and retires it on done.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bif.done === 1'b1) done_total++;
         if (exp_q.size() > 0) begin
            mon_e = exp_q[0];
            chk("reg_rd", bif.reg_rd, (pcyc == mon_e.done_cyc - 1) || (pcyc == mon_e.done_cyc - 2));
            if (bif.reg_rd === 1'b1) chk("reg_sel", bif.reg_sel, mon_e.ra);
            chk("done", bif.done, pcyc == mon_e.done_cyc);
            if (bif.done === 1'b1) begin
               void'(exp_q.pop_front());
               chk("con_ff", bif.con_ff, mon_e.con);
               chk("pc_load", bif.pc_load, mon_e.con);
               chk("pc_out", bif.pc_out, mon_e.pc);
            end else if (pcyc > mon_e.done_cyc) begin
               void'(exp_q.pop_front());
            end
         end else if (bif.done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", pcyc);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (bif.ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bif.ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got %0b expected 1", bif.ready);
      end
   endtask

   task automatic run(input logic [3:0] ra, input logic [1:0] c2, input logic [18:0] disp,
                      input logic [31:0] pc, input logic [31:0] bus,
                      input logic exp_con, input logic [31:0] exp_pc, input bit hold);
      exp_t e;
      wait_ready();
      bif.ir    = {5'b10110, ra, 2'b11, c2, disp};
      bif.pc_in = pc;
      bif.start = 1'b1;
      e.done_cyc = pcyc + 3;
      e.ra  = ra;
      e.con = exp_con;
      e.pc  = exp_pc;
      exp_q.push_back(e);
      if (exp_con) exp_taken++; else exp_nt++;
      @(negedge clk);
      if (!hold) bif.start = 1'b0;
      bif.ir       = 32'hFFFF_FFFF;
      bif.pc_in    = 32'hA5A5_A5A5;
      bif.bus_data = 32'h1234_5678;
      @(negedge clk);
      bif.bus_data = bus;
      @(negedge clk);
      bif.bus_data = 32'h1234_5678;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dt;
      rst_n        = 1'b0;
      bif.start    = 1'b0;
      bif.ir       = '0;
      bif.pc_in    = '0;
      bif.bus_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bif.ready, 1);
      chk("rst_reg_rd", bif.reg_rd, 0);
      chk("rst_reg_sel", bif.reg_sel, 0);
      chk("rst_con_ff", bif.con_ff, 0);
      chk("rst_pc_out", bif.pc_out, 0);
      chk("rst_pc_load", bif.pc_load, 0);
      chk("rst_done", bif.done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run(4'd3,  2'b00, 19'h00010, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0110, 1'b0);
      run(4'd5,  2'b01, 19'h00010, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_0110, 1'b0);
      run(4'd7,  2'b10, 19'h7FFFF, 32'h0000_2000, 32'h8000_0000, 1'b0, 32'h0000_1FFF, 1'b0);
      run(4'd8,  2'b11, 19'h7FFFF, 32'h0000_2000, 32'h8000_0000, 1'b1, 32'h0000_1FFF, 1'b0);
      run(4'd15, 2'b00, 19'h00020, 32'hFFFF_FFF0, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0);
      run(4'd10, 2'b10, 19'h40000, 32'h0000_0400, 32'h0000_0001, 1'b1, 32'hFFFC_0400, 1'b0);
      run(4'd11, 2'b11, 19'h00000, 32'h0000_0010, 32'h7FFF_FFFF, 1'b0, 32'h0000_0010, 1'b0);
      run(4'd12, 2'b01, 19'h00001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0);
      // start held high: one accept every four cycles, extra start ignored
      run(4'd1,  2'b00, 19'h00004, 32'h0000_3000, 32'h0000_0000, 1'b1, 32'h0000_3004, 1'b1);
      run(4'd2,  2'b01, 19'h00004, 32'h0000_3004, 32'h0000_0000, 1'b0, 32'h0000_3008, 1'b1);
      run(4'd9,  2'b11, 19'h7FFF0, 32'h0000_5000, 32'hFFFF_FFF0, 1'b1, 32'h0000_4FF0, 1'b0);

      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drained", exp_q.size(), 0);
`ifdef BRANCH_STATS_EN
      chk("taken_cnt", bif.taken_cnt, exp_taken);
      chk("not_taken_cnt", bif.not_taken_cnt, exp_nt);
`endif

      // Abort a branch in EVAL with reset.
      wait_ready();
      dt = done_total;
      bif.ir    = {5'b10110, 4'd6, 2'b11, 2'b00, 19'h00010};
      bif.pc_in = 32'h0000_0100;
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      @(negedge clk);
      bif.bus_data = 32'h0000_0000;
      rst_n = 1'b0;
      #1;
      chk("abort_ready", bif.ready, 1);
      chk("abort_reg_rd", bif.reg_rd, 0);
      chk("abort_reg_sel", bif.reg_sel, 0);
      chk("abort_con_ff", bif.con_ff, 0);
      chk("abort_pc_out", bif.pc_out, 0);
      chk("abort_pc_load", bif.pc_load, 0);
      chk("abort_done", bif.done, 0);
`ifdef BRANCH_STATS_EN
      chk("abort_taken_cnt", bif.taken_cnt, 0);
      chk("abort_not_taken_cnt", bif.not_taken_cnt, 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("no_done_after_abort", done_total, dt);
      chk("ready_after_abort", bif.ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
